block_spi_master: RTL and testbench

- SPI master (initiator) that drives the same 16-bit frame our SPI slave receiver decodes: address byte, then data byte, MSB first, SPI mode 0 (CPOL=0, CPHA=0).
- Lets FPGA logic write register frames to an SPI peripheral or to a second FPGA running the slave receiver.
- Returns the byte shifted in on MISO during the data byte.
- Sits between internal control logic (start/address/data handshake) and the SPI pins.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/block_spi_tick.sv | 43 ++++
 rtl/block_spi_master.sv | 169 ++++++++++++++++
 tb/tb_block_spi_master.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI frame definition: one address byte then one data byte, MSB first, mode 0.
// The master and the slave receiver both import this so the frame format is defined once.
package spi_pkg;

  localparam int SPI_ADDR_BITS  = 8;
  localparam int SPI_DATA_BITS  = 8;
  localparam int SPI_FRAME_BITS = SPI_ADDR_BITS + SPI_DATA_BITS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Divider counter width; never narrower than one bit so CLK_DIV=1 still has a counter.
  function automatic int div_width(input int div);
    return (div > 32'sd1) ? $clog2(div) : 32'sd1;
  endfunction

endpackage

// File: rtl/block_spi_tick.sv
// SCK half-period divider: one-cycle tick every CLK_DIV enabled cycles, restartable.
module block_spi_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = div_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: held at zero while disabled or restarting, wraps after LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !enable) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/block_spi_master.sv
// Mode-0 SPI master sending {address, data} frames and returning the MISO byte
// captured during the data phase. Every pin and status output comes straight from a flop.
module block_spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [SPI_ADDR_BITS-1:0] address_in,
  input  logic [SPI_DATA_BITS-1:0] data_in,
  output logic                     busy,
  output logic                     done,
  output logic [SPI_DATA_BITS-1:0] read_data,
  output logic                     SPI_SCK,
  output logic                     SPI_CS,
  output logic                     SPI_MOSI,
  input  logic                     SPI_MISO
);

  localparam logic [4:0] LAST_EDGE = 5'(SPI_FRAME_BITS);

  spi_state_e                state_q, state_d;
  logic [SPI_FRAME_BITS-1:0] tx_q, tx_d;
  logic [SPI_DATA_BITS-1:0]  rx_q, rx_d;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic                      sck_q, sck_d;
  logic                      cs_q, cs_d;
  logic                      mosi_q, mosi_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [SPI_DATA_BITS-1:0]  rdata_q, rdata_d;
  logic                      tick;
  logic                      tick_restart;
  logic                      tick_enable;

  assign tick_enable  = (state_q != ST_IDLE);
  assign tick_restart = (state_d != state_q);

  block_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (tick_enable),
    .restart (tick_restart),
    .tick    (tick)
  );

  // Frame sequencer: next state plus next value of every output and shift register.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        // The first MOSI bit comes from the port because tx_q loads on this same edge.
        if (start) begin
          state_d   = ST_SETUP;
          tx_d      = {address_in, data_in};
          bit_cnt_d = 5'd0;
          cs_d      = 1'b0;
          mosi_d    = address_in[SPI_ADDR_BITS-1];
          busy_d    = 1'b1;
        end else begin
          cs_d  = 1'b1;
          sck_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d   = ST_SHIFT;
          sck_d     = 1'b1;
          rx_d      = {rx_q[SPI_DATA_BITS-2:0], SPI_MISO};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sck_q) begin
            sck_d = 1'b0;
            // After the last rising edge MOSI keeps bit 0 through HOLD.
            if (bit_cnt_q == LAST_EDGE) begin
              state_d = ST_HOLD;
            end else begin
              tx_d   = {tx_q[SPI_FRAME_BITS-2:0], 1'b0};
              mosi_d = tx_q[SPI_FRAME_BITS-2];
            end
          end else begin
            sck_d     = 1'b1;
            rx_d      = {rx_q[SPI_DATA_BITS-2:0], SPI_MISO};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          rdata_d = rx_q;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, shift and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tx_q      <= {SPI_FRAME_BITS{1'b0}};
      rx_q      <= {SPI_DATA_BITS{1'b0}};
      bit_cnt_q <= 5'd0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= {SPI_DATA_BITS{1'b0}};
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign read_data = rdata_q;
  assign SPI_SCK   = sck_q;
  assign SPI_CS    = cs_q;
  assign SPI_MOSI  = mosi_q;

endmodule

// File: tb/tb_block_spi_master.sv
// Directed plus randomized bench for block_spi_master with CLK_DIV=4 and CLK_DIV=1 instances,
// a behavioural SPI slave, and frame timing derived from cycle 0 = the edge that accepts start.
module tb_block_spi_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  address_in = 8'h00;
  logic [7:0]  data_in = 8'h00;
  logic [15:0] miso_pat = 16'h0000;
  logic        spi_miso;

  logic       busy4, done4, sck4, cs4, mosi4;
  logic [7:0] rd4;
  logic       busy1, done1, sck1, cs1, mosi1;
  logic [7:0] rd1;

  logic       o_busy, o_done, o_sck, o_cs, o_mosi;
  logic [7:0] o_rd;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [15:0] mosi_word = 16'h0000;
  logic [4:0]  rise_cnt = 5'd0;
  logic [3:0]  miso_idx;

  always #5 clk = ~clk;

  block_spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel),
    .address_in(address_in), .data_in(data_in),
    .busy(busy4), .done(done4), .read_data(rd4),
    .SPI_SCK(sck4), .SPI_CS(cs4), .SPI_MOSI(mosi4), .SPI_MISO(spi_miso)
  );

  block_spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start & sel),
    .address_in(address_in), .data_in(data_in),
    .busy(busy1), .done(done1), .read_data(rd1),
    .SPI_SCK(sck1), .SPI_CS(cs1), .SPI_MOSI(mosi1), .SPI_MISO(spi_miso)
  );

  assign o_busy = sel ? busy1 : busy4;
  assign o_done = sel ? done1 : done4;
  assign o_sck  = sel ? sck1  : sck4;
  assign o_cs   = sel ? cs1   : cs4;
  assign o_mosi = sel ? mosi1 : mosi4;
  assign o_rd   = sel ? rd1   : rd4;

  // Slave model: collects MOSI on each SCK rise and serves miso_pat MSB first.
  always @(negedge o_cs or posedge o_sck) begin
    if (o_sck) begin
      mosi_word <= {mosi_word[14:0], o_mosi};
      rise_cnt  <= rise_cnt + 5'd1;
    end else begin
      mosi_word <= 16'h0000;
      rise_cnt  <= 5'd0;
    end
  end
  assign miso_idx = 4'd15 - rise_cnt[3:0];
  assign spi_miso = rise_cnt[4] ? 1'b0 : miso_pat[miso_idx];

  always @(posedge clk) begin
    if (o_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame; inj>0 pulses start (address 0xFF) at that cycle while busy.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] d,
                           input logic [15:0] mp, input int inj);
    int D, dn0, cs_fall, sck_rise, done_at, busy_low;
    logic [15:0] word;
    logic [7:0]  rd;
    logic        cs_at_done;
    D = sel ? 1 : 4;
    cs_fall = -1; sck_rise = -1; done_at = -1; busy_low = -1;
    word = 16'h0; rd = 8'h0; cs_at_done = 1'b0;
    @(negedge clk);
    address_in = a; data_in = d; miso_pat = mp; start = 1'b1; dn0 = done_cnt;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40 * D + 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start = 1'b0; address_in = ~a; data_in = ~d; end
      if (cyc == inj) begin start = 1'b1; address_in = 8'hFF; end
      if (cyc == inj + 1) start = 1'b0;
      if (!o_cs && cs_fall < 0) cs_fall = cyc;
      if (o_sck && sck_rise < 0) sck_rise = cyc;
      if (o_done && done_at < 0) begin
        done_at = cyc; rd = o_rd; cs_at_done = o_cs; word = mosi_word;
      end
      if (!o_busy) begin busy_low = cyc; break; end
    end
    start = 1'b0;
    check("cs_fall_cycle",  32'(cs_fall),  32'(1));
    check("sck_rise_cycle", 32'(sck_rise), 32'(1 + D));
    check("done_cycle",     32'(done_at),  32'(1 + 33 * D));
    check("busy_low_cycle", 32'(busy_low), 32'(1 + 34 * D));
    check("mosi_frame",     32'(word),     32'({a, d}));
    check("read_data",      32'(rd),       32'(mp[7:0]));
    check("cs_high_at_done", 32'(cs_at_done), 32'(1));
    check("done_pulses",    32'(done_cnt - dn0), 32'(1));
    check("sck_rises",      32'(rise_cnt), 32'(16));
    repeat (2 * D + 2) @(negedge clk);
    check("idle_after_frame", 32'({o_cs, o_busy, o_rd}), 32'({1'b1, 1'b0, mp[7:0]}));
  endtask

  // Two frames with start held high; the second frame's inputs change during the first.
  task automatic run_b2b(input logic [7:0] a0, input logic [7:0] d0, input logic [7:0] a1,
                         input logic [7:0] d1, input logic [15:0] mp0, input logic [15:0] mp1);
    int D, done_a, done_b, cs_high, busy_low;
    logic [15:0] word_a, word_b;
    logic [7:0]  rd_a, rd_b;
    D = sel ? 1 : 4;
    done_a = -1; done_b = -1; cs_high = 0; busy_low = -1;
    word_a = 16'h0; word_b = 16'h0; rd_a = 8'h0; rd_b = 8'h0;
    @(negedge clk);
    address_in = a0; data_in = d0; miso_pat = mp0; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 80 * D + 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin address_in = a1; data_in = d1; end
      if (o_done && done_a < 0) begin
        done_a = cyc; word_a = mosi_word; rd_a = o_rd; miso_pat = mp1;
      end else if (o_done && done_b < 0) begin
        done_b = cyc; word_b = mosi_word; rd_b = o_rd; start = 1'b0;
      end
      if (done_a >= 0 && done_b < 0 && o_cs) cs_high++;
      if (done_b >= 0 && !o_busy) begin busy_low = cyc; break; end
    end
    start = 1'b0;
    check("b2b_done1_cycle", 32'(done_a), 32'(1 + 33 * D));
    // The second frame's cycle 0 is the first cycle with busy low, 1+34D.
    check("b2b_done_spacing", 32'(done_b - done_a), 32'(34 * D + 1));
    check("b2b_frame1", 32'(word_a), 32'({a0, d0}));
    check("b2b_frame2", 32'(word_b), 32'({a1, d1}));
    check("b2b_rd1", 32'(rd_a), 32'(mp0[7:0]));
    check("b2b_rd2", 32'(rd_b), 32'(mp1[7:0]));
    check("b2b_cs_gap_ge_D", 32'(cs_high >= D), 32'(1));
    check("b2b_busy_low", 32'(busy_low >= 0), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_pins", 32'({o_cs, o_sck, o_mosi, o_busy, o_done}), 32'(5'b10000));
    check("reset_rd",   32'(o_rd), 32'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write, then start-while-busy with address 0xFF at cycle 50.
    run_frame(8'hA5, 8'h3C, 16'h0096, -1);
    run_frame(8'hA5, 8'h3C, 16'h5A96, 50);
    for (int i = 0; i < 3; i++) begin
      run_frame(8'($urandom), 8'($urandom), 16'($urandom), -1);
    end

    // Divider of one.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(8'h80, 8'h01, 16'hFFFF, -1);
    for (int i = 0; i < 2; i++) begin
      run_frame(8'($urandom), 8'($urandom), 16'($urandom), -1);
    end
    run_b2b(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            16'($urandom), 16'($urandom));

    // Reset mid-frame at cycle 70, then a clean frame.
    sel = 1'b0;
    repeat (2) @(negedge clk);
    begin
      int dn0;
      @(negedge clk);
      address_in = 8'h5C; data_in = 8'hE7; miso_pat = 16'h00C3; start = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc < 70; cyc++) begin
        @(negedge clk);
        if (cyc == 1) start = 1'b0;
      end
      @(negedge clk);
      dn0 = done_cnt;
      reset_n = 1'b0;
      #1;
      check("midreset_pins", 32'({o_cs, o_sck, o_busy, o_done}), 32'(4'b1000));
      check("midreset_rd",   32'(o_rd), 32'(0));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (150) @(negedge clk);
      check("midreset_no_done", 32'(done_cnt - dn0), 32'(0));
    end
    run_frame(8'($urandom), 8'($urandom), 16'($urandom), -1);
    run_b2b(8'h12, 8'hEF, 8'h34, 8'hCD, 16'h00A7, 16'h0039);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
